// File: rtl/writeback_pkg.sv
// Shared types and constants for the register write-back stage.
//   state_e      : write-back FSM state (IDLE, LOAD_WAIT)
//   FUNCT3_*     : RV32I load funct3 encodings recognised by load_extend
package writeback_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/register_writeback_if.sv
// Request-side bus of the write-back stage: execute results, load issue and
// memory load return.
//   master : core / memory side (drives requests, observes exec_ready)
//   slave  : register_writeback
//
// Handshake: an execute result transfers on a cycle where exec_valid and
// exec_ready are both high; exec_valid with its payload is held until then.
// load_issue and mem_data_valid have no ready: load_issue is taken only
// while busy=0, and mem_data_valid is a one-cycle pulse that is always taken
// while a load is outstanding.
interface register_writeback_if #(
    parameter int AddressBitWidth = 5,
    parameter int DataBitWidth    = 32
);
    logic                       exec_valid;
    logic [AddressBitWidth-1:0] exec_rd;
    logic [DataBitWidth-1:0]    exec_data;
    logic                       exec_ready;

    logic                       load_issue;
    logic [AddressBitWidth-1:0] load_rd;
    logic [2:0]                 load_funct3;
    logic [1:0]                 load_addr_lsb;

    logic                       mem_data_valid;
    logic [DataBitWidth-1:0]    mem_data;

    modport master (
        output exec_valid, exec_rd, exec_data,
        input  exec_ready,
        output load_issue, load_rd, load_funct3, load_addr_lsb,
        output mem_data_valid, mem_data
    );

    modport slave (
        input  exec_valid, exec_rd, exec_data,
        output exec_ready,
        input  load_issue, load_rd, load_funct3, load_addr_lsb,
        input  mem_data_valid, mem_data
    );
endinterface

// File: rtl/register_writeback_load_extend.sv
// Combinational load alignment and sign/zero extension.
//   funct3   in : RV32I load funct3 (unknown encodings behave as LW)
//   addr_lsb in : byte offset; halfword lane uses addr_lsb[1] only
//   word     in : aligned 32-bit word from memory
//   data     out: extended register value
module load_extend
    import writeback_pkg::*;
#(
    parameter int DataBitWidth = 32
) (
    input  logic [2:0]              funct3,
    input  logic [1:0]              addr_lsb,
    input  logic [DataBitWidth-1:0] word,
    output logic [DataBitWidth-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lsb)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lsb[1] ? word[31:16] : word[15:0];

        data = word;
        case (funct3)
            FUNCT3_LB:  data = {{(DataBitWidth-8){byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  data = {{(DataBitWidth-16){half_sel[15]}}, half_sel};
            FUNCT3_LW:  data = word;
            FUNCT3_LBU: data = {{(DataBitWidth-8){1'b0}}, byte_sel};
            FUNCT3_LHU: data = {{(DataBitWidth-16){1'b0}}, half_sel};
            default:    data = word;
        endcase
    end
endmodule

// File: rtl/register_writeback.sv
// Write-back stage driving the register file's single write port.
// Merges single-cycle execute results with one outstanding load.
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : execute results, load issue, memory load return
//   rs1, rs2          : decoder source registers
//   hazard            : decoder must stall
//   busy              : a load is outstanding
//   rd, rd_write_enable, rd_data : registered register-file write port
//   state             : current FSM state (debug)
// Optional feature, macro WRITEBACK_FORWARD_EN: adds rs1_fwd/rs2_fwd so the
// decoder can take rd_data directly; the in-flight write then no longer stalls.
module register_writeback
    import writeback_pkg::*;
#(
    parameter int AddressBitWidth = 5,
    parameter int DataBitWidth    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    register_writeback_if.slave        bus,
    input  logic [AddressBitWidth-1:0] rs1,
    input  logic [AddressBitWidth-1:0] rs2,
    output logic                       hazard,
    output logic                       busy,
    output logic [AddressBitWidth-1:0] rd,
    output logic                       rd_write_enable,
    output logic [DataBitWidth-1:0]    rd_data,
    output state_e                     state
`ifdef WRITEBACK_FORWARD_EN
    ,
    output logic                       rs1_fwd,
    output logic                       rs2_fwd
`endif
);
    state_e                     state_q, state_d;
    logic [AddressBitWidth-1:0] pending_rd;
    logic [2:0]                 pending_funct3;
    logic [1:0]                 pending_lsb;
    logic [DataBitWidth-1:0]    load_value;

    logic load_accept, load_return, waw_block, exec_fire;
    logic load_hit, inflight_rs1, inflight_rs2;

    load_extend #(.DataBitWidth(DataBitWidth)) u_load_extend (
        .funct3   (pending_funct3),
        .addr_lsb (pending_lsb),
        .word     (bus.mem_data),
        .data     (load_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pending_rd     <= '0;
            pending_funct3 <= FUNCT3_LW;
            pending_lsb    <= 2'd0;
        end else begin
            state_q <= state_d;
            if (load_accept) begin
                pending_rd     <= bus.load_rd;
                pending_funct3 <= bus.load_funct3;
                pending_lsb    <= bus.load_addr_lsb;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        load_accept = 1'b0;
        load_return = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_issue) begin
                    load_accept = 1'b1;
                    state_d     = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (bus.mem_data_valid) begin
                    load_return = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The load return owns the write port in its cycle; an execute write to
    // the pending register is held back so it cannot be overwritten by the load.
    assign waw_block      = (state_q == LOAD_WAIT) && (bus.exec_rd == pending_rd)
                            && (bus.exec_rd != '0);
    assign bus.exec_ready = !load_return && !waw_block;
    assign exec_fire      = bus.exec_valid && bus.exec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd              <= '0;
            rd_write_enable <= 1'b0;
            rd_data         <= '0;
        end else if (load_return) begin
            rd              <= pending_rd;
            rd_write_enable <= (pending_rd != '0);
            rd_data         <= load_value;
        end else if (exec_fire) begin
            rd              <= bus.exec_rd;
            rd_write_enable <= (bus.exec_rd != '0);
            rd_data         <= bus.exec_data;
        end else begin
            rd_write_enable <= 1'b0;
        end
    end

    assign busy  = (state_q == LOAD_WAIT);
    assign state = state_q;

    assign load_hit     = (state_q == LOAD_WAIT) && (pending_rd != '0)
                          && ((rs1 == pending_rd) || (rs2 == pending_rd));
    // The register file commits one edge after rd_write_enable, so a reader
    // in this cycle would still see the old value.
    assign inflight_rs1 = rd_write_enable && (rd != '0) && (rs1 == rd);
    assign inflight_rs2 = rd_write_enable && (rd != '0) && (rs2 == rd);

`ifdef WRITEBACK_FORWARD_EN
    assign rs1_fwd = inflight_rs1;
    assign rs2_fwd = inflight_rs2;
    assign hazard  = load_hit;
`else
    assign hazard  = load_hit || inflight_rs1 || inflight_rs2;
`endif
endmodule
